// File: rtl/pipeline_pkg.sv
// Shared types for the 5-stage core's pipeline control.
// FSM state encoding and architectural register constants.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/saturating_counter.sv
// Up-counter that sticks at all-ones.
// Used for pipeline performance statistics.
module saturating_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush generation for the IF/ID, ID/EX, EX/MEM, MEM/WB registers
// and PC: load-use, EX redirects and multi-cycle data-memory waits.
module pipeline_hazard_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned MAX_MEM_WAIT = 16,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           ID_Rs1,
  input  logic [4:0]           ID_Rs2,
  input  logic                 ID_UsesRs1,
  input  logic                 ID_UsesRs2,
  input  logic [4:0]           EX_Rd,
  input  logic                 EX_MemRead,
  input  logic                 EX_Redirect,
  input  logic                 MEM_MemRead,
  input  logic                 MEM_MemWrite,
  input  logic                 dmem_ready,
  output logic                 Pc_Stall,
  output logic                 IF_ID_Stall,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Stall,
  output logic                 ID_EX_Flush,
  output logic                 EX_MEM_Stall,
  output logic                 MEM_WB_Flush,
  output logic                 Mem_Timeout,
  output logic [CNT_WIDTH-1:0] Stall_Count,
  output logic [CNT_WIDTH-1:0] Flush_Count
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_MEM_WAIT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  logic mem_op;
  logic mem_busy;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic timed_out;
  logic hold;
  logic redir;
  logic lu_stall;

  assign mem_op    = MEM_MemRead | MEM_MemWrite;
  assign mem_busy  = mem_op & ~dmem_ready;
  assign rs1_hit   = ID_UsesRs1 & (ID_Rs1 == EX_Rd);
  assign rs2_hit   = ID_UsesRs2 & (ID_Rs2 == EX_Rd);
  assign load_use  = EX_MemRead & (EX_Rd != REG_X0)
                   & (rs1_hit | rs2_hit);
  assign timed_out = (state_q == TIMEOUT);

  // Mutually exclusive causes, already ordered by priority
  assign hold     = ~reset & (timed_out | mem_busy);
  assign redir    = ~reset & ~hold & EX_Redirect;
  assign lu_stall = ~reset & ~hold & ~EX_Redirect & load_use;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready || !mem_op) begin
          state_d = RUN;
          wait_d  = 8'd0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = TIMEOUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      TIMEOUT: begin
        state_d = TIMEOUT;
      end
      default: begin
        state_d = RUN;
        wait_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    Pc_Stall     = 1'b0;
    IF_ID_Stall  = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Stall  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Stall = 1'b0;
    MEM_WB_Flush = 1'b0;
    unique case (1'b1)
      hold: begin
        Pc_Stall     = 1'b1;
        IF_ID_Stall  = 1'b1;
        ID_EX_Stall  = 1'b1;
        EX_MEM_Stall = 1'b1;
        MEM_WB_Flush = 1'b1;
      end
      redir: begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end
      lu_stall: begin
        Pc_Stall    = 1'b1;
        IF_ID_Stall = 1'b1;
        ID_EX_Flush = 1'b1;
      end
      default: begin
        Pc_Stall = 1'b0;
      end
    endcase
  end

  assign Mem_Timeout = timed_out;

  saturating_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (Pc_Stall),
    .count(Stall_Count)
  );

  saturating_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_flush_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (redir),
    .count(Flush_Count)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed vectors, a rule-level
// reference model checked every cycle, and literal anchor checks.
module tb_pipeline_hazard_controller;

  localparam int MAXW = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [4:0]    ID_Rs1, ID_Rs2, EX_Rd;
  logic          ID_UsesRs1, ID_UsesRs2;
  logic          EX_MemRead, EX_Redirect;
  logic          MEM_MemRead, MEM_MemWrite, dmem_ready;
  logic          Pc_Stall, IF_ID_Stall, IF_ID_Flush;
  logic          ID_EX_Stall, ID_EX_Flush;
  logic          EX_MEM_Stall, MEM_WB_Flush, Mem_Timeout;
  logic [CW-1:0] Stall_Count, Flush_Count;

  int n_vec = 0;
  int n_err = 0;

  int m_run = 0;
  bit m_to  = 1'b0;
  int m_sc  = 0;
  int m_fc  = 0;

  pipeline_hazard_controller #(
    .MAX_MEM_WAIT(MAXW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ID_Rs1      (ID_Rs1),
    .ID_Rs2      (ID_Rs2),
    .ID_UsesRs1  (ID_UsesRs1),
    .ID_UsesRs2  (ID_UsesRs2),
    .EX_Rd       (EX_Rd),
    .EX_MemRead  (EX_MemRead),
    .EX_Redirect (EX_Redirect),
    .MEM_MemRead (MEM_MemRead),
    .MEM_MemWrite(MEM_MemWrite),
    .dmem_ready  (dmem_ready),
    .Pc_Stall    (Pc_Stall),
    .IF_ID_Stall (IF_ID_Stall),
    .IF_ID_Flush (IF_ID_Flush),
    .ID_EX_Stall (ID_EX_Stall),
    .ID_EX_Flush (ID_EX_Flush),
    .EX_MEM_Stall(EX_MEM_Stall),
    .MEM_WB_Flush(MEM_WB_Flush),
    .Mem_Timeout (Mem_Timeout),
    .Stall_Count (Stall_Count),
    .Flush_Count (Flush_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic bit busy_now();
    return (MEM_MemRead || MEM_MemWrite) && !dmem_ready;
  endfunction

  // {pc, if_stall, if_flush, id_stall, id_flush, ex_stall, wb_flush}
  function automatic logic [6:0] expect_ctl();
    bit lu;
    lu = EX_MemRead && (EX_Rd != 5'd0) &&
         ((ID_UsesRs1 && ID_Rs1 == EX_Rd) ||
          (ID_UsesRs2 && ID_Rs2 == EX_Rd));
    if (reset)                 return 7'b0000000;
    if (m_to || busy_now())    return 7'b1101011;
    if (EX_Redirect)           return 7'b0010100;
    if (lu)                    return 7'b1100100;
    return 7'b0000000;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [6:0] e;
    if (reset) begin
      m_run <= 0;
      m_to  <= 1'b0;
      m_sc  <= 0;
      m_fc  <= 0;
    end else begin
      e = expect_ctl();
      if (e[6] && m_sc < CMAX) m_sc <= m_sc + 1;
      if (e[4] && m_fc < CMAX) m_fc <= m_fc + 1;
      if (busy_now()) begin
        m_run <= m_run + 1;
        if (m_run + 1 == MAXW) m_to <= 1'b1;
      end else begin
        m_run <= 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [6:0] e;
    e = expect_ctl();
    chk("Pc_Stall",     32'(Pc_Stall),     32'(e[6]));
    chk("IF_ID_Stall",  32'(IF_ID_Stall),  32'(e[5]));
    chk("IF_ID_Flush",  32'(IF_ID_Flush),  32'(e[4]));
    chk("ID_EX_Stall",  32'(ID_EX_Stall),  32'(e[3]));
    chk("ID_EX_Flush",  32'(ID_EX_Flush),  32'(e[2]));
    chk("EX_MEM_Stall", 32'(EX_MEM_Stall), 32'(e[1]));
    chk("MEM_WB_Flush", 32'(MEM_WB_Flush), 32'(e[0]));
    chk("Mem_Timeout",  32'(Mem_Timeout),  32'(m_to));
    chk("Stall_Count",  32'(Stall_Count),  32'(m_sc));
    chk("Flush_Count",  32'(Flush_Count),  32'(m_fc));
  end

  task automatic idle();
    ID_Rs1 = 5'd0; ID_Rs2 = 5'd0; EX_Rd = 5'd0;
    ID_UsesRs1 = 1'b0; ID_UsesRs2 = 1'b0;
    EX_MemRead = 1'b0; EX_Redirect = 1'b0;
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    MEM_MemRead = 1'b1;
    #12;
    chk("rst Pc_Stall",     32'(Pc_Stall),     32'd0);
    chk("rst MEM_WB_Flush", 32'(MEM_WB_Flush), 32'd0);
    chk("rst Stall_Count",  32'(Stall_Count),  32'd0);
    chk("rst Mem_Timeout",  32'(Mem_Timeout),  32'd0);
    idle();
    tick();
    reset = 1'b0;

    // load-use on rs2
    EX_MemRead = 1'b1; EX_Rd = 5'd5; ID_Rs2 = 5'd5; ID_UsesRs2 = 1'b1;
    @(negedge clk);
    chk("lu Pc_Stall",    32'(Pc_Stall),    32'd1);
    chk("lu IF_ID_Stall", 32'(IF_ID_Stall), 32'd1);
    chk("lu ID_EX_Flush", 32'(ID_EX_Flush), 32'd1);
    tick();
    idle();
    @(negedge clk);
    chk("lu release",  32'(Pc_Stall),    32'd0);
    chk("lu count",    32'(Stall_Count), 32'd1);

    // x0 destination, then unused operand
    tick();
    EX_MemRead = 1'b1; EX_Rd = 5'd0; ID_Rs1 = 5'd0; ID_UsesRs1 = 1'b1;
    @(negedge clk);
    chk("x0 no stall", 32'(Pc_Stall), 32'd0);
    tick();
    EX_Rd = 5'd7; ID_Rs1 = 5'd7; ID_UsesRs1 = 1'b0;
    @(negedge clk);
    chk("unused no stall", 32'(Pc_Stall), 32'd0);
    tick();

    // redirect beats load-use
    EX_MemRead = 1'b1; EX_Rd = 5'd3; ID_Rs1 = 5'd3; ID_UsesRs1 = 1'b1;
    EX_Redirect = 1'b1;
    @(negedge clk);
    chk("rd IF_ID_Flush", 32'(IF_ID_Flush), 32'd1);
    chk("rd ID_EX_Flush", 32'(ID_EX_Flush), 32'd1);
    chk("rd Pc_Stall",    32'(Pc_Stall),    32'd0);
    tick();
    idle();
    @(negedge clk);
    chk("rd Flush_Count", 32'(Flush_Count), 32'd1);
    chk("rd Stall_Count", 32'(Stall_Count), 32'd1);

    // 3-cycle memory wait
    tick();
    MEM_MemRead = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mw Pc_Stall",     32'(Pc_Stall),     32'd1);
      chk("mw EX_MEM_Stall", 32'(EX_MEM_Stall), 32'd1);
      chk("mw MEM_WB_Flush", 32'(MEM_WB_Flush), 32'd1);
      tick();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    chk("mw release", 32'(Pc_Stall), 32'd0);
    tick();
    idle();
    @(negedge clk);
    chk("mw Stall_Count", 32'(Stall_Count), 32'd4);
    chk("mw Mem_Timeout", 32'(Mem_Timeout), 32'd0);

    // redirect held through a 2-cycle wait
    tick();
    MEM_MemRead = 1'b1; EX_Redirect = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rw no flush", 32'(IF_ID_Flush), 32'd0);
      chk("rw stall",    32'(Pc_Stall),    32'd1);
      tick();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    chk("rw flush on release", 32'(IF_ID_Flush), 32'd1);
    tick();
    idle();
    @(negedge clk);
    chk("rw Stall_Count", 32'(Stall_Count), 32'd6);
    chk("rw Flush_Count", 32'(Flush_Count), 32'd2);

    // flush counter saturation: 2 + 14 redirects
    tick();
    EX_Redirect = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    idle();
    @(negedge clk);
    chk("fc saturate", 32'(Flush_Count), 32'd15);

    // timeout after MAXW not-ready cycles
    tick();
    MEM_MemWrite = 1'b1;
    for (int i = 0; i < MAXW; i++) begin
      @(negedge clk);
      chk("to not yet", 32'(Mem_Timeout), 32'd0);
      tick();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    chk("to Mem_Timeout", 32'(Mem_Timeout), 32'd1);
    chk("to stall held",  32'(Pc_Stall),    32'd1);
    chk("to Stall_Count", 32'(Stall_Count), 32'd10);
    for (int i = 0; i < 6; i++) tick();
    @(negedge clk);
    chk("sc saturate",    32'(Stall_Count), 32'd15);
    chk("to still stuck", 32'(EX_MEM_Stall), 32'd1);

    // asynchronous reset mid-TIMEOUT
    #1 reset = 1'b1;
    #1;
    chk("ar Mem_Timeout", 32'(Mem_Timeout), 32'd0);
    chk("ar Stall_Count", 32'(Stall_Count), 32'd0);
    chk("ar Flush_Count", 32'(Flush_Count), 32'd0);
    chk("ar Pc_Stall",    32'(Pc_Stall),    32'd0);
    #1 reset = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    chk("post idle", 32'(Pc_Stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Generates the stall and flush controls consumed by the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register of the 5-stage RISC-V core.
- Detects load-use hazards in ID and control redirects resolved in EX.
- Uses an FSM and a wait counter to freeze the pipeline during multi-cycle data-memory accesses, with timeout detection.
- Keeps saturating performance counters for stall cycles and flush events.

Parameters:
- MAX_MEM_WAIT, 16: maximum consecutive data-memory wait cycles before timeout. Legal range 2..255.
- CNT_WIDTH, 32: width of the performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- ID_Rs1  in  5  rs1 of the instruction in ID.
- ID_Rs2  in  5  rs2 of the instruction in ID.
- ID_UsesRs1  in  1  instruction in ID reads rs1.
- ID_UsesRs2  in  1  instruction in ID reads rs2.
- EX_Rd  in  5  destination register of the instruction in EX.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_Redirect  in  1  taken branch or jump resolved in EX.
- MEM_MemRead  in  1  load in MEM.
- MEM_MemWrite  in  1  store in MEM.
- dmem_ready  in  1  data memory completes the access this cycle.
- Pc_Stall  out  1  hold PC.
- IF_ID_Stall  out  1  hold IF/ID.
- IF_ID_Flush  out  1  bubble IF/ID.
- ID_EX_Stall  out  1  hold ID/EX.
- ID_EX_Flush  out  1  bubble ID/EX.
- EX_MEM_Stall  out  1  hold EX/MEM.
- MEM_WB_Flush  out  1  bubble MEM/WB.
- Mem_Timeout  out  1  sticky memory timeout error.
- Stall_Count  out  CNT_WIDTH  cycles with Pc_Stall asserted (saturating).
- Flush_Count  out  CNT_WIDTH  redirect events (saturating).

Behaviour:
- Reset is asynchronous and active-high; the clock is clk. While reset is high and on release:
  - state = RUN, wait_cnt = 0.
  - Mem_Timeout = 0, Stall_Count = 0, Flush_Count = 0.
  - All stall and flush outputs are forced to 0.
- Internal terms:
  - mem_busy = (MEM_MemRead | MEM_MemWrite) & ~dmem_ready.
  - load_use = EX_MemRead & (EX_Rd != 0) & ((ID_UsesRs1 & ID_Rs1 == EX_Rd) | (ID_UsesRs2 & ID_Rs2 == EX_Rd)).
- All stall and flush outputs are Mealy (same-cycle combinational from inputs and state). Priority: TIMEOUT > mem_busy > EX_Redirect > load_use.
- FSM states and transitions:
  - RUN: if mem_busy, go to MEM_WAIT with wait_cnt = 1. Otherwise remain in RUN.
  - MEM_WAIT: if dmem_ready or no memory op is present, go to RUN with wait_cnt = 0. Else if wait_cnt == MAX_MEM_WAIT-1, go to TIMEOUT. Else wait_cnt increments.
  - TIMEOUT: terminal until reset. Mem_Timeout = 1.
- Outputs when mem_busy is true (in any state) or the state is TIMEOUT:
  - Pc_Stall = IF_ID_Stall = ID_EX_Stall = EX_MEM_Stall = 1.
  - MEM_WB_Flush = 1.
  - IF_ID_Flush = ID_EX_Flush = 0. Redirect and load-use handling are deferred because the EX and ID contents are frozen and re-evaluated once released.
- Outputs when EX_Redirect is true (and no memory stall): IF_ID_Flush = ID_EX_Flush = 1; all stalls 0. A redirect overrides a simultaneous load_use, since the ID instruction is on the wrong path.
- Outputs when load_use is true (and neither of the above): Pc_Stall = IF_ID_Stall = 1 and ID_EX_Flush = 1, inserting one bubble. On the next cycle the load has moved to MEM, so load_use deasserts without extra state.
- Otherwise all stall and flush outputs are 0.
- The cycle dmem_ready rises releases the stall in that same cycle. Stall latency is therefore exactly N cycles for N not-ready cycles.
- Stall_Count increments on every clocked cycle with Pc_Stall = 1. Flush_Count increments on every cycle where IF_ID_Flush is asserted because of a redirect. Both saturate at all-ones.
- An x0 destination never produces load_use.

Decomposition:
- Shared package `pipeline_pkg`: FSM state enum (RUN, MEM_WAIT, TIMEOUT) and the x0 register index constant.
- Sub-module `saturating_counter` (parameter WIDTH; inputs clk, reset, inc; output count), instantiated twice.

Test Plan:
- Load-use:
  - Stimulus: EX_MemRead=1, EX_Rd=5, ID_Rs2=5, ID_UsesRs2=1 for one cycle.
  - Response: Pc_Stall=IF_ID_Stall=ID_EX_Flush=1 that cycle only, and Stall_Count=1.
- x0 and unused operand:
  - Stimulus: EX_Rd=0 matching ID_Rs1; separately EX_Rd=7, ID_Rs1=7, ID_UsesRs1=0.
  - Response: no stall in either case.
- Redirect beats load-use:
  - Stimulus: EX_Redirect=1 simultaneous with a load_use match.
  - Response: IF_ID_Flush=ID_EX_Flush=1, Pc_Stall=0, Flush_Count=1.
- Memory wait:
  - Stimulus: MEM_MemRead=1 with dmem_ready low for 3 cycles, then high.
  - Response: all four stalls and MEM_WB_Flush high for exactly 3 cycles, state returns to RUN, Stall_Count=3.
- Timeout:
  - Stimulus: MAX_MEM_WAIT=4, MEM_MemWrite=1, dmem_ready held low.
  - Response: Mem_Timeout rises on cycle 4 and stalls stay high while dmem_ready later rises. Asynchronous reset mid-TIMEOUT clears Mem_Timeout, counters and outputs immediately.
- Redirect during memory wait:
  - Stimulus: EX_Redirect=1 held throughout a 2-cycle wait.
  - Response: flush outputs stay 0 during the wait and assert once on the release cycle (only after the wait ends, not during it).
